// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine driving a 32-bit ALU with directed + LFSR vectors.
// Optional macro ALU_BIST_ZERO_CHECK_EN adds the Zero flag to the mismatch check.
`timescale 1ns/1ps

package alu_bist_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ops;
endpackage

module alu_bist #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [2:0]  first_fail_op,
  output logic [31:0] first_fail_a,
  output logic [31:0] first_fail_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);
  import alu_bist_pkg::*;

  localparam logic [31:0] MASK   = 32'h8020_0003;
  localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B = (~SEED == 32'h0) ? 32'h1 : ~SEED;
  localparam int          VW     = $clog2(NUM_VECTORS);
  localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_idx, nop;
  logic [VW-1:0] vec_idx, nvec;
  logic [31:0]   lfsr_a, lfsr_b;
  logic [31:0]   exp_res;
  logic          exp_zero, mismatch, launch, adv, last_op, last_vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
  endfunction

  function automatic logic [2:0] op_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SUB;
      3'd2:    return ALU_AND;
      3'd3:    return ALU_OR;
      default: return ALU_SLT;
    endcase
  endfunction

  assign last_op  = (op_idx == 3'd4);
  assign last_vec = (vec_idx == LAST_VEC);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (last_op && last_vec) ? S_DONE : S_DRIVE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_DRIVE) || (state == S_CHECK);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_count == 16'h0);
  end

  // Golden model evaluated on the registered operands the ALU is seeing.
  always_comb begin
    exp_res = 32'h0;
    case (alu_ctrl)
      ALU_ADD: exp_res = alu_a + alu_b;
      ALU_SUB: exp_res = alu_a - alu_b;
      ALU_AND: exp_res = alu_a & alu_b;
      ALU_OR:  exp_res = alu_a | alu_b;
      ALU_SLT: exp_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: exp_res = 32'h0;
    endcase
    exp_zero = (exp_res == 32'h0);
  end

`ifdef ALU_BIST_ZERO_CHECK_EN
  assign mismatch = (alu_result != exp_res) || (alu_zero != exp_zero);
`else
  logic unused_zero;
  assign unused_zero = alu_zero ^ exp_zero;
  assign mismatch    = (alu_result != exp_res);
`endif

  // Select the vector to be loaded on this edge (first of a run, or the next one).
  always_comb begin
    launch = ((state == S_IDLE) || (state == S_DONE)) && start;
    adv    = (state == S_CHECK) && !(last_op && last_vec);
    nop    = op_idx;
    nvec   = vec_idx;
    if (launch) begin
      nop  = 3'd0;
      nvec = '0;
    end else if (adv) begin
      if (last_vec) begin
        nop  = op_idx + 3'd1;
        nvec = '0;
      end else begin
        nvec = vec_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_idx        <= 3'd0;
      vec_idx       <= '0;
      lfsr_a        <= SEED_A;
      lfsr_b        <= SEED_B;
      alu_a         <= 32'h0;
      alu_b         <= 32'h0;
      alu_ctrl      <= ALU_ADD;
      err_count     <= 16'h0;
      first_fail_op <= ALU_ADD;
      first_fail_a  <= 32'h0;
      first_fail_b  <= 32'h0;
    end else begin
      if (launch) begin
        lfsr_a        <= SEED_A;
        lfsr_b        <= SEED_B;
        err_count     <= 16'h0;
        first_fail_op <= ALU_ADD;
        first_fail_a  <= 32'h0;
        first_fail_b  <= 32'h0;
      end else if ((state == S_CHECK) && mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
        if (err_count == 16'h0) begin
          first_fail_op <= alu_ctrl;
          first_fail_a  <= alu_a;
          first_fail_b  <= alu_b;
        end
      end
      if (launch || adv) begin
        op_idx   <= nop;
        vec_idx  <= nvec;
        alu_ctrl <= op_code(nop);
        if (32'(nvec) < 32'd4) begin
          case (nvec[1:0])
            2'd0:    begin alu_a <= 32'h0000_0000; alu_b <= 32'h0000_0000; end
            2'd1:    begin alu_a <= 32'hFFFF_FFFF; alu_b <= 32'h0000_0001; end
            2'd2:    begin alu_a <= 32'h8000_0000; alu_b <= 32'h7FFF_FFFF; end
            default: begin alu_a <= 32'h7FFF_FFFF; alu_b <= 32'h8000_0000; end
          endcase
        end else begin
          alu_a  <= lfsr_a;
          alu_b  <= lfsr_b;
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed-vector bench for alu_bist with a behavioural ALU that can inject faults.
`timescale 1ns/1ps

module tb_alu_bist;
  import alu_bist_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[20];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fault_mode = 0;  // 0 ok, 1 Result bit0 stuck-at-1, 2 Zero stuck-at-0
  int   n_even, n_zero;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start6;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [2:0]  ff_op, alu_ctrl;
  logic [31:0] ff_a, ff_b, alu_a, alu_b, alu_result;
  logic        alu_zero;

  logic        busy6, done6, pass6;
  logic [15:0] err6;
  logic [2:0]  ff_op6, ctrl6;
  logic [31:0] ff_a6, ff_b6, a6, b6, res6;
  logic        zero6;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    if (fault_mode == 1) alu_result[0] = 1'b1;
    alu_zero = (fault_mode == 2) ? 1'b0 : (alu_result == 32'h0);
  end

  always_comb begin
    res6  = alu_fn(ctrl6, a6, b6);
    zero6 = (res6 == 32'h0);
  end

  alu_bist #(.NUM_VECTORS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_op(ff_op), .first_fail_a(ff_a), .first_fail_b(ff_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_bist #(.NUM_VECTORS(6)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6), .busy(busy6), .done(done6), .pass(pass6),
    .err_count(err6), .first_fail_op(ff_op6), .first_fail_a(ff_a6), .first_fail_b(ff_b6),
    .alu_a(a6), .alu_b(b6), .alu_ctrl(ctrl6), .alu_result(res6), .alu_zero(zero6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r);
    tbl[i].op = op; tbl[i].a = a; tbl[i].b = b; tbl[i].res = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " err_count"}, err_count, 0);
    check({tag, " alu_a"}, alu_a, 0);
    check({tag, " alu_b"}, alu_b, 0);
    check({tag, " alu_ctrl"}, alu_ctrl, ALU_ADD);
    check({tag, " ff_op"}, ff_op, ALU_ADD);
    check({tag, " ff_a"}, ff_a, 0);
    check({tag, " ff_b"}, ff_b, 0);
  endtask

  // Full 40-cycle run of the NUM_VECTORS=4 instance; operands checked every cycle.
  task automatic run_full(input string tag, input int extra_start_at);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("%s ctrl k%0d", tag, k), alu_ctrl, tbl[k/2].op);
      check($sformatf("%s a k%0d", tag, k), alu_a, tbl[k/2].a);
      check($sformatf("%s b k%0d", tag, k), alu_b, tbl[k/2].b);
      if (k == 39) check({tag, " done early"}, done, 0);
      if (k == extra_start_at) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    check({tag, " done at 40"}, done, 1);
    check({tag, " busy at 40"}, busy, 0);
  endtask

  initial begin
    set_vec( 0, ALU_ADD, 32'h0, 32'h0, 32'h0);
    set_vec( 1, ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0);
    set_vec( 2, ALU_ADD, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF);
    set_vec( 3, ALU_ADD, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
    set_vec( 4, ALU_SUB, 32'h0, 32'h0, 32'h0);
    set_vec( 5, ALU_SUB, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE);
    set_vec( 6, ALU_SUB, 32'h80000000, 32'h7FFFFFFF, 32'h1);
    set_vec( 7, ALU_SUB, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
    set_vec( 8, ALU_AND, 32'h0, 32'h0, 32'h0);
    set_vec( 9, ALU_AND, 32'hFFFFFFFF, 32'h1, 32'h1);
    set_vec(10, ALU_AND, 32'h80000000, 32'h7FFFFFFF, 32'h0);
    set_vec(11, ALU_AND, 32'h7FFFFFFF, 32'h80000000, 32'h0);
    set_vec(12, ALU_OR,  32'h0, 32'h0, 32'h0);
    set_vec(13, ALU_OR,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF);
    set_vec(14, ALU_OR,  32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF);
    set_vec(15, ALU_OR,  32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
    set_vec(16, ALU_SLT, 32'h0, 32'h0, 32'h0);
    set_vec(17, ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1);
    set_vec(18, ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h1);
    set_vec(19, ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h0);

    // Hand table gives 10 even results and 9 zero results.
    n_even = 0; n_zero = 0;
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].res[0] == 1'b0) n_even++;
      if (tbl[i].res == 32'h0)   n_zero++;
    end

    reset = 1'b1; start = 1'b0; start6 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("idle");

    fault_mode = 0;
    run_full("good", -1);
    check("good pass", pass, 1);
    check("good err", err_count, 0);
    repeat (3) @(posedge clk);
    #1;
    check("good done held", done, 1);

    fault_mode = 1;
    run_full("bit0", -1);
    check("bit0 pass", pass, 0);
    check("bit0 err", err_count, 32'(n_even));
    check("bit0 err const", err_count, 10);
    check("bit0 ff_op", ff_op, ALU_ADD);
    check("bit0 ff_a", ff_a, 0);
    check("bit0 ff_b", ff_b, 0);

    fault_mode = 2;
    run_full("zero", -1);
`ifdef ALU_BIST_ZERO_CHECK_EN
    check("zero pass", pass, 0);
    check("zero err", err_count, 32'(n_zero));
    check("zero ff_op", ff_op, ALU_ADD);
    check("zero ff_a", ff_a, 0);
    check("zero ff_b", ff_b, 0);
`else
    check("zero pass", pass, 1);
    check("zero err", err_count, 0);
`endif

    // Second start mid-run must be ignored.
    fault_mode = 0;
    run_full("restart", 7);
    check("restart pass", pass, 1);

    // Reset 15 cycles into a run, then rerun and compare the operand trace.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    check("pre-reset a", alu_a, 32'h7FFFFFFF);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    reset = 1'b0;
    run_full("rerun", -1);
    check("rerun pass", pass, 1);

    // Longer instance: random vectors come from the LFSRs, carried across ops.
    @(negedge clk); start6 = 1'b1;
    @(posedge clk); #1; start6 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 8) begin
        check("lfsr v4 a", a6, 32'hACE12345);
        check("lfsr v4 b", b6, ~32'hACE12345);
      end
      if (k == 10) begin
        check("lfsr v5 a", a6, 32'hD65091A1);
        check("lfsr v5 b", b6, step(~32'hACE12345));
      end
      if (k == 20) begin
        check("lfsr sub v4 ctrl", ctrl6, ALU_SUB);
        check("lfsr sub v4 a", a6, step(32'hD65091A1));
      end
      @(posedge clk); #1;
    end
    check("n6 done at 60", done6, 1);
    check("n6 pass", pass6, 1);
    check("n6 err", err6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
